// File: rtl/generador_imm_segmentado.sv
// Two-stage pipelined RISC-V immediate generator with valid/ready on both sides.
// S1 captures the raw instruction, S2 holds the decoded, sign-extended immediate.
module generador_imm_segmentado #(
    parameter int unsigned Bits      = 64,
    parameter int unsigned Ancho     = 32,
    parameter int unsigned AnchoCont = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Ancho-1:0]     Offset,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Bits-1:0]      Inmediato,
    output logic [2:0]           formato,
    output logic                 ilegal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AnchoCont-1:0] cont_ilegal
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    function automatic logic es_ilegal(input logic [6:0] op);
        case (op)
            OpLoad, OpOpImm, OpJalr, OpStore, OpBranch, OpLui, OpAuipc, OpJal: es_ilegal = 1'b0;
            default:                                                          es_ilegal = 1'b1;
        endcase
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [Ancho-1:0] s1_insn_q, s1_insn_d;
    logic             s2_valid_q, s2_valid_d;
    logic [Bits-1:0]  imm_q, imm_d;
    logic [2:0]       fmt_q, fmt_d;
    logic             il_q, il_d;
    logic [AnchoCont-1:0] cont_q, cont_d;

    logic        s2_adv, s1_adv, in_xfer;
    logic [63:0] imm64;
    logic [2:0]  dec_fmt;
    logic        dec_il;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !reset;
    assign in_xfer  = in_valid && in_ready;

    // Build the immediate at 64 bits and truncate, so Bits=32 needs no special case.
    always_comb begin
        imm64   = '0;
        dec_fmt = 3'd7;
        dec_il  = 1'b1;
        case (s1_insn_q[6:0])
            OpLoad, OpOpImm, OpJalr: begin
                imm64   = {{52{s1_insn_q[31]}}, s1_insn_q[31:20]};
                dec_fmt = 3'd0;
                dec_il  = 1'b0;
            end
            OpStore: begin
                imm64   = {{52{s1_insn_q[31]}}, s1_insn_q[31:25], s1_insn_q[11:7]};
                dec_fmt = 3'd1;
                dec_il  = 1'b0;
            end
            OpBranch: begin
                imm64   = {{51{s1_insn_q[31]}}, s1_insn_q[31], s1_insn_q[7],
                           s1_insn_q[30:25], s1_insn_q[11:8], 1'b0};
                dec_fmt = 3'd2;
                dec_il  = 1'b0;
            end
            OpLui, OpAuipc: begin
                imm64   = {{32{s1_insn_q[31]}}, s1_insn_q[31:12], 12'b0};
                dec_fmt = 3'd3;
                dec_il  = 1'b0;
            end
            OpJal: begin
                imm64   = {{43{s1_insn_q[31]}}, s1_insn_q[31], s1_insn_q[19:12],
                           s1_insn_q[20], s1_insn_q[30:21], 1'b0};
                dec_fmt = 3'd4;
                dec_il  = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_insn_d  = s1_insn_q;
        s2_valid_d = s2_valid_q;
        imm_d      = imm_q;
        fmt_d      = fmt_q;
        il_d       = il_q;
        cont_d     = cont_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_insn_d = Offset;
        end
        // S2 only changes when it may advance, so a stalled result stays put.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                imm_d = imm64[Bits-1:0];
                fmt_d = dec_fmt;
                il_d  = dec_il;
            end
        end
        if (in_xfer && es_ilegal(Offset[6:0]) && (cont_q != '1)) cont_d = cont_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_insn_q  <= '0;
            s2_valid_q <= 1'b0;
            imm_q      <= '0;
            fmt_q      <= '0;
            il_q       <= 1'b0;
            cont_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_insn_q  <= s1_insn_d;
            s2_valid_q <= s2_valid_d;
            imm_q      <= imm_d;
            fmt_q      <= fmt_d;
            il_q       <= il_d;
            cont_q     <= cont_d;
        end
    end

    assign Inmediato   = imm_q;
    assign formato     = fmt_q;
    assign ilegal      = il_q;
    assign out_valid   = s2_valid_q;
    assign cont_ilegal = cont_q;

endmodule
